mem_bus_arbiter: RTL and testbench

Shares the single 64-bit memory port (rw/addr/write/read) between two requesters.
- Port 0 is instruction fetch; port 1 is data load/store.
- Sequences each access through a fixed memory latency, then returns read data with a one-cycle done pulse.
- Sits between the CPU fetch/LSU logic and the memory model.
- Round-robin arbitration on contention. One transaction in flight at a time.

---
 rtl/mem_bus_arbiter_if.sv | 63 ++++++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundle of the two requester ports and the shared memory port
//               around mem_bus_arbiter. The slave modport is the arbiter's
//               view; the master modport is the view of the requesters and
//               the memory model that surround it.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);

    // Requester port 0 (instruction fetch)
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    // Requester port 1 (data load/store)
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;

    // Shared memory port
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write;
    logic [DATA_W-1:0] read;

    // Status
    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_done, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_done, m1_rdata,
        output rw, addr, write,
        input  read,
        output busy
    );

    // Requester / memory-model side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_done, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_done, m1_rdata,
        input  rw, addr, write,
        output read,
        input  busy
    );

endinterface : mem_bus_arbiter_if
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between an instruction-fetch port (0)
//               and a load/store port (1). One transaction in flight; each
//               access holds the bus for MEM_LATENCY cycles, then a one-cycle
//               RESP state pulses the granted port's done. Contention is
//               resolved round-robin against the last granted port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int MEM_LATENCY = 1,   // legal range 1..15
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    // Value of the beat counter on the final ACCESS cycle. The counter is
    // 4 bits, which covers every legal latency without wrapping.
    localparam logic [3:0] c_LAST_BEAT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Grant decision made in IDLE
    logic              w_gnt_vld;
    logic              w_gnt_sel;     // 0 = port 0, 1 = port 1
    logic              w_last_beat;   // final ACCESS cycle

    // Registered copy of the granted request and bus drive
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_write;
    logic              r_rw;
    logic              r_we;
    logic              r_gnt;
    logic              r_last_gnt;
    logic [3:0]        r_cnt;

    // Per-port read-data buffers; they only change on a completed read
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and grant selection
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_vld   = 1'b0;
        w_gnt_sel   = 1'b0;
        w_last_beat = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    w_gnt_vld   = 1'b1;
                    // Both requesting: the port not served last time wins.
                    if (bus.m0_req && bus.m1_req) begin
                        w_gnt_sel = ~r_last_gnt;
                    end else begin
                        w_gnt_sel = bus.m1_req;
                    end
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == c_LAST_BEAT) begin
                    w_last_beat = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the granted request onto the bus, count the access beats and
    // capture read data on the last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_write    <= '0;
            r_rw       <= 1'b0;
            r_we       <= 1'b0;
            r_gnt      <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= 4'd0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            if (w_gnt_vld) begin
                r_addr     <= w_gnt_sel ? bus.m1_addr  : bus.m0_addr;
                r_write    <= w_gnt_sel ? bus.m1_wdata : bus.m0_wdata;
                r_rw       <= w_gnt_sel ? bus.m1_we    : bus.m0_we;
                r_we       <= w_gnt_sel ? bus.m1_we    : bus.m0_we;
                r_gnt      <= w_gnt_sel;
                r_last_gnt <= w_gnt_sel;
                r_cnt      <= 4'd0;
            end else if (r_state == S_IDLE) begin
                r_rw <= 1'b0;
            end

            if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (w_last_beat) begin
                // The write strobe covers exactly the ACCESS cycles.
                r_rw <= 1'b0;
                if (!r_we) begin
                    if (r_gnt) begin
                        r_rdata1 <= bus.read;
                    end else begin
                        r_rdata0 <= bus.read;
                    end
                end
            end
        end
    end

    // Output drive: bus signals straight from registers, done/busy decoded
    // from state so they drop together with the reset edge
    assign bus.rw       = r_rw;
    assign bus.addr     = r_addr;
    assign bus.write    = r_write;
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_rdata = r_rdata1;
    assign bus.m0_done  = (r_state == S_RESP) && !r_gnt;
    assign bus.m1_done  = (r_state == S_RESP) &&  r_gnt;
    assign bus.busy     = (r_state != S_IDLE);

endmodule : mem_bus_arbiter
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Directed bench for mem_bus_arbiter. Three instances cover
//               memory latencies 1, 3 and 4; each has a combinational memory
//               model on its read port. Expected values are hand-derived.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus1 ();
    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus3 ();
    mem_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus4 ();

    mem_bus_arbiter #(.MEM_LATENCY(1), .ADDR_W(64), .DATA_W(64)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );
    mem_bus_arbiter #(.MEM_LATENCY(3), .ADDR_W(64), .DATA_W(64)) u_dut_l3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );
    mem_bus_arbiter #(.MEM_LATENCY(4), .ADDR_W(64), .DATA_W(64)) u_dut_l4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Memory contents: two fixed words, everything else reads as ~addr
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        case (a)
            64'h40:  return 64'h13;
            64'h80:  return 64'h99;
            default: return ~a;
        endcase
    endfunction

    assign bus1.read = mem_fn(bus1.addr);
    assign bus3.read = mem_fn(bus3.addr);
    assign bus4.read = mem_fn(bus4.addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
        bus3.m0_req = 0; bus3.m0_we = 0; bus3.m0_addr = 0; bus3.m0_wdata = 0;
        bus3.m1_req = 0; bus3.m1_we = 0; bus3.m1_addr = 0; bus3.m1_wdata = 0;
        bus4.m0_req = 0; bus4.m0_we = 0; bus4.m0_addr = 0; bus4.m0_wdata = 0;
        bus4.m1_req = 0; bus4.m1_we = 0; bus4.m1_addr = 0; bus4.m1_wdata = 0;
    endtask

    // Two reset edges; returns in "cycle 0" with rst released
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        adv();
        adv();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset();

        // ---- reset state ----
        check("rst_rw",     bus1.rw,       0);
        check("rst_addr",   bus1.addr,     0);
        check("rst_write",  bus1.write,    0);
        check("rst_done0",  bus1.m0_done,  0);
        check("rst_done1",  bus1.m1_done,  0);
        check("rst_rdata0", bus1.m0_rdata, 0);
        check("rst_rdata1", bus1.m1_rdata, 0);
        check("rst_busy",   bus1.busy,     0);

        // ---- L=1 single read from port 0 ----
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 64'h40;
        adv();  // cycle 1
        check("t1_c1_addr", bus1.addr, 64'h40);
        check("t1_c1_rw",   bus1.rw,   0);
        check("t1_c1_busy", bus1.busy, 1);
        check("t1_c1_done", bus1.m0_done, 0);
        adv();  // cycle 2
        check("t1_c2_done",  bus1.m0_done,  1);
        check("t1_c2_rdata", bus1.m0_rdata, 64'h13);
        check("t1_c2_busy",  bus1.busy,     1);
        adv();  // cycle 3
        bus1.m0_req = 0;
        check("t1_c3_busy", bus1.busy,    0);
        check("t1_c3_done", bus1.m0_done, 0);

        // ---- L=3 write from port 1 ----
        do_reset();
        bus3.m1_req = 1; bus3.m1_we = 1; bus3.m1_addr = 64'h1000; bus3.m1_wdata = 64'hDEADBEEF;
        for (int c = 1; c <= 3; c++) begin
            adv();
            check("t2_rw",    bus3.rw,      1);
            check("t2_addr",  bus3.addr,    64'h1000);
            check("t2_write", bus3.write,   64'hDEADBEEF);
            check("t2_done",  bus3.m1_done, 0);
        end
        adv();  // cycle 4
        bus3.m1_req = 0;
        check("t2_c4_rw",    bus3.rw,       0);
        check("t2_c4_done1", bus3.m1_done,  1);
        check("t2_c4_done0", bus3.m0_done,  0);
        check("t2_c4_rdata", bus3.m1_rdata, 0);
        adv();
        check("t2_c5_done1", bus3.m1_done, 0);

        // ---- L=3 both requesting from reset: alternation ----
        do_reset();
        bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 64'h40;
        bus3.m1_req = 1; bus3.m1_we = 0; bus3.m1_addr = 64'h80;
        for (int c = 1; c <= 20; c++) begin
            logic [1:0] exp_done;
            adv();
            exp_done = (c == 4 || c == 14) ? 2'b01 :
                       (c == 9 || c == 19) ? 2'b10 : 2'b00;
            check($sformatf("t3_done_c%0d", c), {bus3.m1_done, bus3.m0_done}, exp_done);
            if (c == 4 || c == 14) check("t3_rdata0", bus3.m0_rdata, 64'h13);
            if (c == 9 || c == 19) check("t3_rdata1", bus3.m1_rdata, 64'h99);
        end
        bus3.m0_req = 0; bus3.m1_req = 0;

        // ---- L=1 three back-to-back reads on port 0 ----
        do_reset();
        bus1.m0_req = 1; bus1.m0_we = 0; bus1.m0_addr = 64'h40;
        for (int c = 1; c <= 9; c++) begin
            adv();
            if (c == 3) bus1.m0_addr = 64'h80;
            if (c == 6) bus1.m0_addr = 64'h200;
            if (c == 9) bus1.m0_req  = 0;
            check($sformatf("t4_done_c%0d", c), bus1.m0_done, (c == 2 || c == 5 || c == 8));
            if (c == 2) check("t4_rdata_a", bus1.m0_rdata, 64'h13);
            if (c == 5) check("t4_rdata_b", bus1.m0_rdata, 64'h99);
            if (c == 8) check("t4_rdata_c", bus1.m0_rdata, 64'hFFFF_FFFF_FFFF_FDFF);
        end

        // ---- L=4 reset mid-ACCESS, then contention goes to port 0 ----
        do_reset();
        bus4.m0_req = 1; bus4.m0_we = 1; bus4.m0_addr = 64'h500; bus4.m0_wdata = 64'h55;
        adv();  // cycle 1: first ACCESS cycle
        check("t5_c1_rw",   bus4.rw,   1);
        check("t5_c1_addr", bus4.addr, 64'h500);
        adv();  // cycle 2: second ACCESS cycle, assert reset
        check("t5_c2_rw", bus4.rw, 1);
        rst = 1; bus4.m0_req = 0;
        adv();  // cycle 3: after reset edge
        check("t5_c3_rw",    bus4.rw,    0);
        check("t5_c3_addr",  bus4.addr,  0);
        check("t5_c3_write", bus4.write, 0);
        check("t5_c3_busy",  bus4.busy,  0);
        check("t5_c3_done",  {bus4.m1_done, bus4.m0_done}, 0);
        rst = 0;
        bus4.m0_req = 1; bus4.m0_we = 0; bus4.m0_addr = 64'h40;
        bus4.m1_req = 1; bus4.m1_we = 0; bus4.m1_addr = 64'h80;
        adv();  // cycle 4: port 0 should be on the bus
        check("t5_c4_addr", bus4.addr, 64'h40);
        check("t5_c4_busy", bus4.busy, 1);
        for (int c = 4; c <= 7; c++) begin
            if (c > 4) adv();
            check($sformatf("t5_nodone_c%0d", c), {bus4.m1_done, bus4.m0_done}, 0);
        end
        adv();  // cycle 8: RESP for port 0
        check("t5_c8_done",  {bus4.m1_done, bus4.m0_done}, 2'b01);
        check("t5_c8_rdata", bus4.m0_rdata, 64'h13);
        bus4.m0_req = 0; bus4.m1_req = 0;

        // ---- L=3 address changed mid-ACCESS ----
        do_reset();
        bus3.m0_req = 1; bus3.m0_we = 0; bus3.m0_addr = 64'h40;
        adv();  // cycle 1
        check("t6_c1_addr", bus3.addr, 64'h40);
        adv();  // cycle 2
        bus3.m0_addr = 64'h80;
        check("t6_c2_addr", bus3.addr, 64'h40);
        adv();  // cycle 3
        check("t6_c3_addr", bus3.addr, 64'h40);
        adv();  // cycle 4
        bus3.m0_req = 0;
        check("t6_c4_done",  bus3.m0_done,  1);
        check("t6_c4_rdata", bus3.m0_rdata, 64'h13);
        check("t6_c4_addr",  bus3.addr,     64'h40);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_bus_arbiter
`default_nettype wire
